id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register and operand-delivery stage directly upstream of the ALU.

---
 rtl/id_ex_operand_stage_if.sv | 53 +++++
 rtl/id_ex_operand_stage.sv | 110 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of ID-side inputs, hazard/flush controls, forwarding sources and ALU-facing
// outputs of the ID/EX operand stage.
interface id_ex_operand_stage_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_ready;
    logic [3:0]       id_aluop;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_rt_data;
    logic [31:0]      id_imm;
    logic             id_alusrc;
    logic [4:0]       id_dest;
    logic             id_regwr;
    logic             id_memrd;
    logic             ex_stall;
    logic             flush;
    logic [4:0]       mem_dest;
    logic             mem_regwr;
    logic [31:0]      mem_result;
    logic [4:0]       wb_dest;
    logic             wb_regwr;
    logic [31:0]      wb_data;
    logic             ex_valid;
    logic [3:0]       ex_aluop;
    logic [31:0]      port_a;
    logic [31:0]      port_b;
    logic [31:0]      ex_store_data;
    logic [4:0]       ex_dest;
    logic             ex_regwr;
    logic             ex_memrd;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_aluop, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rs_data, id_rt_data, id_imm, id_alusrc, id_dest, id_regwr, id_memrd,
               ex_stall, flush, mem_dest, mem_regwr, mem_result, wb_dest, wb_regwr, wb_data,
        input  id_ready, ex_valid, ex_aluop, port_a, port_b, ex_store_data,
               ex_dest, ex_regwr, ex_memrd, stall_cnt
    );

    modport slave (
        input  id_valid, id_aluop, id_rs, id_rt, id_use_rs, id_use_rt,
               id_rs_data, id_rt_data, id_imm, id_alusrc, id_dest, id_regwr, id_memrd,
               ex_stall, flush, mem_dest, mem_regwr, mem_result, wb_dest, wb_regwr, wb_data,
        output id_ready, ex_valid, ex_aluop, port_a, port_b, ex_store_data,
               ex_dest, ex_regwr, ex_memrd, stall_cnt
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: holds raw regfile operands, forwards from
// EX/MEM and MEM/WB, inserts a one-cycle bubble on load-use and counts those stalls.
module id_ex_operand_stage #(
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);

    logic             valid_q;
    logic [3:0]       aluop_q;
    logic [4:0]       rs_q;
    logic [4:0]       rt_q;
    logic [31:0]      rs_data_q;
    logic [31:0]      rt_data_q;
    logic [31:0]      imm_q;
    logic             alusrc_q;
    logic [4:0]       dest_q;
    logic             regwr_q;
    logic             memrd_q;
    logic [CNT_W-1:0] cnt_q;

    logic             haz;
    logic [31:0]      fwd_rs;
    logic [31:0]      fwd_rt;

    // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] v,
        input logic        m_wr,
        input logic [4:0]  m_dst,
        input logic [31:0] m_val,
        input logic        w_wr,
        input logic [4:0]  w_dst,
        input logic [31:0] w_val
    );
        logic [31:0] res;
        res = v;
        if (m_wr && (r != 5'd0) && (m_dst == r))
            res = m_val;
        else if (w_wr && (r != 5'd0) && (w_dst == r))
            res = w_val;
        return res;
    endfunction

    always_comb begin
        haz = valid_q && memrd_q && (dest_q != 5'd0) &&
              ((bus.id_use_rs && (bus.id_rs == dest_q)) ||
               (bus.id_use_rt && (bus.id_rt == dest_q)));
        fwd_rs = fwd(rs_q, rs_data_q, bus.mem_regwr, bus.mem_dest, bus.mem_result,
                     bus.wb_regwr, bus.wb_dest, bus.wb_data);
        fwd_rt = fwd(rt_q, rt_data_q, bus.mem_regwr, bus.mem_dest, bus.mem_result,
                     bus.wb_regwr, bus.wb_dest, bus.wb_data);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            aluop_q   <= 4'd0;
            rs_q      <= 5'd0;
            rt_q      <= 5'd0;
            rs_data_q <= 32'd0;
            rt_data_q <= 32'd0;
            imm_q     <= 32'd0;
            alusrc_q  <= 1'b0;
            dest_q    <= 5'd0;
            regwr_q   <= 1'b0;
            memrd_q   <= 1'b0;
            cnt_q     <= '0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
            memrd_q <= 1'b0;
        end else if (!bus.ex_stall) begin
            if (haz) begin
                valid_q <= 1'b0;
                regwr_q <= 1'b0;
                memrd_q <= 1'b0;
                if (bus.id_valid && (cnt_q != '1))
                    cnt_q <= cnt_q + 1'b1;
            end else begin
                valid_q   <= bus.id_valid;
                aluop_q   <= bus.id_aluop;
                rs_q      <= bus.id_rs;
                rt_q      <= bus.id_rt;
                rs_data_q <= bus.id_rs_data;
                rt_data_q <= bus.id_rt_data;
                imm_q     <= bus.id_imm;
                alusrc_q  <= bus.id_alusrc;
                dest_q    <= bus.id_dest;
                regwr_q   <= bus.id_regwr;
                memrd_q   <= bus.id_memrd;
            end
        end
    end

    assign bus.id_ready      = !bus.ex_stall && !haz;
    assign bus.ex_valid      = valid_q;
    assign bus.ex_aluop      = aluop_q;
    assign bus.port_a        = fwd_rs;
    assign bus.ex_store_data = fwd_rt;
    assign bus.port_b        = alusrc_q ? imm_q : fwd_rt;
    assign bus.ex_dest       = dest_q;
    assign bus.ex_regwr      = regwr_q && valid_q;
    assign bus.ex_memrd      = memrd_q && valid_q;
    assign bus.stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: expected ALU-side values are queued when an
// instruction is driven and compared one cycle later when the stage presents them.
module tb_id_ex_operand_stage;

    localparam int CNT_W = 2;
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;

    typedef struct packed {
        logic        valid;
        logic [3:0]  aluop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        regwr;
        logic        memrd;
    } exp_t;

    logic clk;
    logic rst;
    int   checkCount;
    int   failCount;
    int   expCnt;
    exp_t sbq[$];

    id_ex_operand_stage_if #(.CNT_W(CNT_W)) bus ();

    id_ex_operand_stage #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] st, input logic [4:0] dst,
                           input logic wr, input logic rd);
        exp_t e;
        e = '{valid: v, aluop: op, a: a, b: b, st: st, dest: dst, regwr: wr, memrd: rd};
        sbq.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            check({tag, "_sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_valid"}, {31'd0, bus.ex_valid}, {31'd0, e.valid});
            check({tag, "_regwr"}, {31'd0, bus.ex_regwr}, {31'd0, e.regwr});
            check({tag, "_memrd"}, {31'd0, bus.ex_memrd}, {31'd0, e.memrd});
            if (e.valid) begin
                check({tag, "_aluop"}, {28'd0, bus.ex_aluop}, {28'd0, e.aluop});
                check({tag, "_port_a"}, bus.port_a, e.a);
                check({tag, "_port_b"}, bus.port_b, e.b);
                check({tag, "_store"}, bus.ex_store_data, e.st);
                check({tag, "_dest"}, {27'd0, bus.ex_dest}, {27'd0, e.dest});
            end
        end
    endtask

    task automatic driveId(input logic v, input logic [3:0] op,
                           input logic [4:0] rs, input logic [31:0] rsd, input logic urs,
                           input logic [4:0] rt, input logic [31:0] rtd, input logic urt,
                           input logic [31:0] imm, input logic src,
                           input logic [4:0] dst, input logic wr, input logic rd);
        bus.id_valid   = v;
        bus.id_aluop   = op;
        bus.id_rs      = rs;
        bus.id_rs_data = rsd;
        bus.id_use_rs  = urs;
        bus.id_rt      = rt;
        bus.id_rt_data = rtd;
        bus.id_use_rt  = urt;
        bus.id_imm     = imm;
        bus.id_alusrc  = src;
        bus.id_dest    = dst;
        bus.id_regwr   = wr;
        bus.id_memrd   = rd;
    endtask

    task automatic setFwd(input logic mwr, input logic [4:0] md, input logic [31:0] mr,
                          input logic wwr, input logic [4:0] wd, input logic [31:0] wv);
        bus.mem_regwr  = mwr;
        bus.mem_dest   = md;
        bus.mem_result = mr;
        bus.wb_regwr   = wwr;
        bus.wb_dest    = wd;
        bus.wb_data    = wv;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        rst = 1'b1;
        driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setFwd(0, 0, 0, 0, 0, 0);
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();

        // Reset state with idle ID
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ex_regwr", {31'd0, bus.ex_regwr}, 32'd0);
        check("rst_port_a", bus.port_a, 32'd0);
        check("rst_port_b", bus.port_b, 32'd0);
        check("rst_stall_cnt", {30'd0, bus.stall_cnt}, 32'd0);
        check("rst_id_ready", {31'd0, bus.id_ready}, 32'd1);

        // ADDI r4 = r1(5) + 7
        driveId(1, ALU_ADD, 5'd1, 32'd5, 1, 5'd0, 32'd0, 0, 32'd7, 1, 5'd4, 1, 0);
        pushExp(1, ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd4, 1, 0);
        applyStimulus();
        checkOutput("addi");

        // rs=r2 with both forwarding sources targeting r2: EX/MEM wins
        driveId(1, ALU_ADD, 5'd2, 32'h99, 1, 5'd0, 32'd0, 0, 32'd1, 1, 5'd5, 1, 0);
        setFwd(1, 5'd2, 32'h10, 1, 5'd2, 32'h20);
        pushExp(1, ALU_ADD, 32'h10, 32'd1, 32'd0, 5'd5, 1, 0);
        applyStimulus();
        checkOutput("fwd_mem");
        bus.ex_stall  = 1'b1;
        bus.mem_regwr = 1'b0;
        #1;
        check("fwd_wb_port_a", bus.port_a, 32'h20);

        // r0 never forwarded on rs; rt=r2 picks up MEM/WB
        bus.ex_stall = 1'b0;
        driveId(1, ALU_ADD, 5'd0, 32'h33, 1, 5'd2, 32'h44, 1, 32'd0, 0, 5'd6, 1, 0);
        setFwd(1, 5'd0, 32'h77, 1, 5'd2, 32'h20);
        pushExp(1, ALU_ADD, 32'h33, 32'h20, 32'h20, 5'd6, 1, 0);
        applyStimulus();
        checkOutput("fwd_r0");
        setFwd(0, 0, 0, 0, 0, 0);

        // Load followed by a dependent ADD
        driveId(1, ALU_ADD, 5'd1, 32'h100, 1, 5'd0, 32'd0, 0, 32'd4, 1, 5'd3, 1, 1);
        pushExp(1, ALU_ADD, 32'h100, 32'd4, 32'd0, 5'd3, 1, 1);
        applyStimulus();
        checkOutput("lw");
        driveId(1, ALU_ADD, 5'd4, 32'd1, 1, 5'd3, 32'd2, 1, 32'd0, 0, 5'd6, 1, 0);
        #1;
        check("lu_id_ready", {31'd0, bus.id_ready}, 32'd0);
        pushExp(0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0);
        applyStimulus();
        checkOutput("lu_bubble");
        check("lu_stall_cnt", {30'd0, bus.stall_cnt}, 32'd1);
        check("lu_ready_after", {31'd0, bus.id_ready}, 32'd1);
        setFwd(1, 5'd3, 32'hABC, 0, 0, 0);
        pushExp(1, ALU_ADD, 32'd1, 32'hABC, 32'hABC, 5'd6, 1, 0);
        applyStimulus();
        checkOutput("lu_accept");
        setFwd(0, 0, 0, 0, 0, 0);

        // Downstream stall holds outputs for three cycles
        driveId(1, ALU_SUB, 5'd5, 32'h50, 1, 5'd6, 32'h60, 1, 32'd0, 0, 5'd7, 1, 0);
        pushExp(1, ALU_SUB, 32'h50, 32'h60, 32'h60, 5'd7, 1, 0);
        applyStimulus();
        checkOutput("sub");
        driveId(1, ALU_AND, 5'd8, 32'h80, 1, 5'd9, 32'h90, 1, 32'hFFFF_FFF0, 1, 5'd10, 1, 0);
        bus.ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_id_ready", {31'd0, bus.id_ready}, 32'd0);
            pushExp(1, ALU_SUB, 32'h50, 32'h60, 32'h60, 5'd7, 1, 0);
            applyStimulus();
            checkOutput("stall_hold");
        end
        bus.ex_stall = 1'b0;
        pushExp(1, ALU_AND, 32'h80, 32'hFFFF_FFF0, 32'h90, 5'd10, 1, 0);
        applyStimulus();
        checkOutput("stall_release");

        // Flush beats a simultaneous stall
        bus.ex_stall = 1'b1;
        bus.flush    = 1'b1;
        pushExp(0, ALU_ADD, 32'd0, 32'd0, 32'd0, 5'd0, 0, 0);
        applyStimulus();
        checkOutput("flush");
        bus.ex_stall = 1'b0;
        bus.flush    = 1'b0;

        // Reset while a load-use hazard is pending
        driveId(1, ALU_ADD, 5'd1, 32'h100, 1, 5'd0, 32'd0, 0, 32'd4, 1, 5'd3, 1, 1);
        pushExp(1, ALU_ADD, 32'h100, 32'd4, 32'd0, 5'd3, 1, 1);
        applyStimulus();
        checkOutput("lw2");
        driveId(1, ALU_ADD, 5'd3, 32'd1, 1, 5'd0, 32'd0, 0, 32'd0, 0, 5'd6, 1, 0);
        #1;
        check("haz_rs_ready", {31'd0, bus.id_ready}, 32'd0);
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
        check("rst_mid_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_mid_memrd", {31'd0, bus.ex_memrd}, 32'd0);
        check("rst_mid_cnt", {30'd0, bus.stall_cnt}, 32'd0);

        // Five load-use hazards saturate the 2-bit counter
        expCnt = 0;
        for (int i = 0; i < 5; i++) begin
            driveId(1, ALU_ADD, 5'd1, 32'h100, 1, 5'd0, 32'd0, 0, 32'd4, 1, 5'd3, 1, 1);
            applyStimulus();
            driveId(1, ALU_ADD, 5'd4, 32'd1, 1, 5'd3, 32'd2, 1, 32'd0, 0, 5'd6, 1, 0);
            applyStimulus();
            expCnt = (expCnt == 3) ? 3 : expCnt + 1;
            check("sat_step", {30'd0, bus.stall_cnt}, expCnt[31:0]);
        end
        check("sat_final", {30'd0, bus.stall_cnt}, 32'd3);
        driveId(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        check("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule
